// File: rtl/tempo_controller_if.sv
// tempo_controller_if: raw speed buttons in, speed level and tick enables out.
interface tempo_controller_if #(
  parameter int LW = 2
);
  logic          speedup;
  logic          speeddown;
  logic [LW-1:0] level;
  logic          at_max;
  logic          at_min;
  logic          play_tick;
  logic          led_tick;
  modport master (output speedup, speeddown, input level, at_max, at_min, play_tick, led_tick);
  modport slave (input speedup, speeddown, output level, at_max, at_min, play_tick, led_tick);
endinterface

// File: rtl/tempo_controller.sv
// tempo_controller: debounced faster/slower buttons drive a saturating speed level and per-channel tick enables.
// Define TEMPO_AUTO_REPEAT_EN to make held buttons auto-repeat their step.
module tempo_controller #(
  parameter int NUM_LEVELS    = 3,
  parameter int DEFAULT_LEVEL = 1,
  parameter int PLAY_EXP_SLOW = 23,
  parameter int LED_EXP_SLOW  = 25,
  parameter int DEBOUNCE_LEN  = 4,
  parameter int REPEAT_DELAY  = 2**26,
  parameter int REPEAT_PERIOD = 2**24,
  localparam int LW = NUM_LEVELS > 1 ? $clog2(NUM_LEVELS) : 1
) (
  input logic clk,
  input logic rst,
  tempo_controller_if.slave bus
);
  localparam int DW = DEBOUNCE_LEN > 1 ? $clog2(DEBOUNCE_LEN + 1) : 1;
  localparam logic [LW-1:0] MAX_L = LW'(NUM_LEVELS - 1);

  if (NUM_LEVELS < 2 || DEFAULT_LEVEL >= NUM_LEVELS || PLAY_EXP_SLOW < NUM_LEVELS ||
      LED_EXP_SLOW < NUM_LEVELS || DEBOUNCE_LEN < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad
    $error("tempo_controller: illegal parameter set");
  end

  // bit 0 is the speedup button, bit 1 speeddown
  logic [1:0]         raw, sync1_q, sync2_q, db_q, db_dly_q, step_q, step_d, deb_hit, req;
  logic [1:0][DW-1:0] deb_q;
  logic [LW-1:0]      level_q, level_d;

  assign raw     = {bus.speeddown, bus.speedup};
  assign step_d  = db_q & ~db_dly_q;
  assign deb_hit = {sync2_q[1] != db_q[1] && deb_q[1] == DW'(DEBOUNCE_LEN - 1),
                    sync2_q[0] != db_q[0] && deb_q[0] == DW'(DEBOUNCE_LEN - 1)};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      step_q   <= '0;
      deb_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      step_q   <= step_d;
      db_q     <= db_q ^ deb_hit;
      for (int b = 0; b < 2; b++)
        deb_q[b] <= sync2_q[b] == db_q[b] || deb_hit[b] ? '0 : deb_q[b] + 1'b1;
    end

`ifdef TEMPO_AUTO_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = RMAX > 1 ? $clog2(RMAX) : 1;
  logic [1:0]         held, armed_q, first_q, rep_q, rep_d;
  logic [1:0][RW-1:0] rpt_q;
  // a button only repeats while it alone is held; armed drops for good on release or conflict
  assign held  = db_q & ~{db_q[0], db_q[1]};
  assign rep_d = {armed_q[1] && held[1] && rpt_q[1] == RW'((first_q[1] ? REPEAT_DELAY : REPEAT_PERIOD) - 1),
                  armed_q[0] && held[0] && rpt_q[0] == RW'((first_q[0] ? REPEAT_DELAY : REPEAT_PERIOD) - 1)};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rpt_q   <= '0;
      armed_q <= '0;
      first_q <= '0;
      rep_q   <= '0;
    end else begin
      armed_q <= held & (armed_q | step_d);
      first_q <= step_d | (first_q & ~rep_d);
      rep_q   <= rep_d;
      for (int b = 0; b < 2; b++)
        rpt_q[b] <= !held[b] || step_d[b] || rep_d[b] ? '0 : rpt_q[b] + 1'b1;
    end
  assign req = step_q | rep_q;
`else
  assign req = step_q;
`endif

  always_comb
    level_d = req == 2'b01 && level_q != MAX_L ? level_q + 1'b1 :
              req == 2'b10 && level_q != '0    ? level_q - 1'b1 : level_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) level_q <= LW'(DEFAULT_LEVEL);
    else level_q <= level_d;

  // the reload value is sampled only at the tick, so a period in progress is never cut short
  for (genvar c = 0; c < 2; c++) begin : g_tick
    localparam int EXP = c == 0 ? PLAY_EXP_SLOW : LED_EXP_SLOW;
    logic [EXP-1:0] cnt_q;
    logic           tick;
    assign tick = cnt_q == '0;
    always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= {EXP{1'b1}} >> DEFAULT_LEVEL;
      else cnt_q <= tick ? {EXP{1'b1}} >> level_q : cnt_q - 1'b1;
  end

  assign bus.level     = level_q;
  assign bus.at_max    = level_q == MAX_L;
  assign bus.at_min    = level_q == '0;
  assign bus.play_tick = g_tick[0].tick;
  assign bus.led_tick  = g_tick[1].tick;
endmodule

// File: tb/tb_tempo_controller.sv
// tb_tempo_controller: directed and random button presses checked against an event-level reference model.
module tb_tempo_controller;
  localparam int P = 4, L = 6, NL = 3, DEF = 1, DB = 4, RD = 20, RP = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tempo_controller_if #(.LW(2)) bus ();
  tempo_controller #(
    .NUM_LEVELS(NL), .DEFAULT_LEVEL(DEF), .PLAY_EXP_SLOW(P), .LED_EXP_SLOW(L),
    .DEBOUNCE_LEN(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0, n_fail = 0;

  // reference model: e counts active edges since reset release; pn/ln are the edges that consume the next tick
  int       e, lvl, pn, ln;
  bit       db[2], dbfut[2], rq[2];
  bit [3:0] sh[2];
  int       base[2], db_e[2], rise_e[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    e = 0;
    lvl = DEF;
    pn = 1 << (P - DEF);
    ln = 1 << (L - DEF);
    for (int b = 0; b < 2; b++) begin
      db[b] = 0; dbfut[b] = 0; rq[b] = 0; sh[b] = '0;
      base[b] = -1; db_e[b] = -1; rise_e[b] = -1;
    end
  endtask

  task automatic model_edge(input bit u, input bit d);
    bit held[2], raw[2], ru, rd;
    raw[0] = u; raw[1] = d;
    e++;
    ru = rq[0]; rd = rq[1]; rq[0] = 0; rq[1] = 0;
    held[0] = db[0] && !db[1];
    held[1] = db[1] && !db[0];
    if (e == pn) pn = e + (1 << (P - lvl));
    if (e == ln) ln = e + (1 << (L - lvl));
`ifdef TEMPO_AUTO_REPEAT_EN
    for (int b = 0; b < 2; b++)
      if (!held[b]) base[b] = -1;
      else if (base[b] >= 0 && e - base[b] >= RD && (e - base[b] - RD) % RP == 0) rq[b] = 1;
`endif
    for (int b = 0; b < 2; b++) begin
      if (rise_e[b] == e) begin
        rq[b] = 1;
        base[b] = held[b] ? e : -1;
      end
      // last DB synchronised samples all opposite to the accepted level -> accepted two edges later
      sh[b] = {sh[b][2:0], raw[b]};
      if (sh[b] == (dbfut[b] ? 4'h0 : 4'hF)) begin
        dbfut[b] = !dbfut[b];
        db_e[b] = e + 2;
      end
    end
    if (ru && !rd && lvl < NL - 1) lvl++;
    else if (rd && !ru && lvl > 0) lvl--;
    for (int b = 0; b < 2; b++)
      if (db_e[b] == e) begin
        if (!db[b] && dbfut[b]) rise_e[b] = e + 1;
        db[b] = dbfut[b];
      end
  endtask

  task automatic check();
    chk($sformatf("level@%0d", e), bus.level, lvl);
    chk($sformatf("at_max@%0d", e), bus.at_max, lvl == NL - 1);
    chk($sformatf("at_min@%0d", e), bus.at_min, lvl == 0);
    chk($sformatf("play_tick@%0d", e), bus.play_tick, e + 1 == pn);
    chk($sformatf("led_tick@%0d", e), bus.led_tick, e + 1 == ln);
  endtask

  task automatic cyc(input bit u, input bit d);
    bus.speedup = u;
    bus.speeddown = d;
    @(posedge clk);
    model_edge(u, d);
    @(negedge clk);
    check();
  endtask

  task automatic press(input bit u, input bit d, input int hold, input int gap);
    repeat (hold) cyc(u, d);
    repeat (gap) cyc(1'b0, 1'b0);
  endtask

  initial begin
    int n;
    bus.speedup = 1'b0;
    bus.speeddown = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_level", bus.level, DEF);
    chk("rst_at_max", bus.at_max, 0);
    chk("rst_at_min", bus.at_min, 0);
    chk("rst_play_tick", bus.play_tick, 0);
    chk("rst_led_tick", bus.led_tick, 0);
    rst = 1'b0;
    model_reset();
    check();
    // idle: level 1, play period 8, led period 32
    repeat (70) cyc(1'b0, 1'b0);
    chk("t1_level", bus.level, 1);
    // clean speedup press, then a second one that saturates
    press(1'b1, 1'b0, 30, 20);
    chk("t2_level", bus.level, 2);
    press(1'b1, 1'b0, 30, 20);
    chk("t2_sat_level", bus.level, 2);
    chk("t2_at_max", bus.at_max, 1);
    press(1'b0, 1'b1, 15, 20);
    chk("t3_pre_level", bus.level, 1);
    // bouncing speedup then held
    for (int i = 0; i < 10; i++) cyc(i % 4 < 2, 1'b0);
    press(1'b1, 1'b0, 15, 20);
    chk("t3_bounce_level", bus.level, 2);
    press(1'b0, 1'b1, 15, 20);
    press(1'b1, 1'b1, 15, 20);
    chk("t4_both_level", bus.level, 1);
    press(1'b0, 1'b1, 15, 20);
    press(1'b0, 1'b1, 15, 20);
    chk("t4_min_level", bus.level, 0);
    chk("t4_at_min", bus.at_min, 1);
    repeat (140) cyc(1'b0, 1'b0);
    // reset while a play tick is high at level 2
    press(1'b1, 1'b0, 15, 20);
    press(1'b1, 1'b0, 15, 20);
    chk("t5_pre_level", bus.level, 2);
    n = 0;
    while (e + 1 != pn && n < 20) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    chk("t5_pre_tick", bus.play_tick, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_play_tick", bus.play_tick, 0);
    chk("t5_rst_led_tick", bus.led_tick, 0);
    chk("t5_rst_level", bus.level, DEF);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check();
    n = 0;
    while (bus.play_tick !== 1'b1 && n < 20) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    chk("t5_first_tick_edge", e + 1, 8);
    repeat (10) cyc(1'b0, 1'b0);
    chk("t5_level", bus.level, 1);
    // long speeddown hold from level 2
    press(1'b1, 1'b0, 15, 20);
    press(1'b0, 1'b1, 60, 30);
`ifdef TEMPO_AUTO_REPEAT_EN
    chk("t6_level", bus.level, 0);
`else
    chk("t6_level", bus.level, 1);
`endif
    // random presses, optionally with bounce, checked every cycle by the model
    for (int k = 0; k < 25; k++) begin
      int kind;
      bit u, d;
      kind = $urandom_range(0, 2);
      u = kind != 1;
      d = kind != 0;
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 8; i++) cyc(u && (i % 4 < 2), d && (i % 4 < 2));
      press(u, d, $urandom_range(2, 45), $urandom_range(3, 25));
    end
    repeat (20) cyc(1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
